// File: rtl/delta_mod_scheduler.sv
// Round-robin scheduler sharing one delta-modulation core across 4 channels, with an event FIFO.
// Optional macro DMS_OFF_SPIKE_EN: report off-spikes as well as on-spikes.
module delta_mod_scheduler #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [15:0] sample,
   input  logic [3:0]  threshold,
   input  logic [3:0]  ch_en,
   output logic [3:0]  core_data,
   output logic [3:0]  core_threshold,
   output logic        core_load_prev,
   output logic [3:0]  core_force_prev,
   output logic        core_off_spike,
   input  logic [1:0]  core_spike,
   input  logic [3:0]  core_prev,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic [3:0]  evt_data,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, EVAL, CAPT} state_t;

   state_t        state;
   logic [1:0]    ch;
   logic [1:0]    last_ch;
   logic [1:0]    base_ch;
   logic [1:0]    next_ch;
   logic [3:0]    prev [4];
   logic [3:0]    load_prev;
   logic          start_next;
   logic [1:0]    spike_m;
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   logic          full;
   logic          push_ok;

   assign core_threshold = threshold;
   assign busy           = (state != IDLE);
   assign start_next     = ena && (ch_en != 4'd0);

`ifdef DMS_OFF_SPIKE_EN
   assign core_off_spike = 1'b1;
   assign spike_m        = core_spike;
`else
   assign core_off_spike = 1'b0;
   assign spike_m        = core_spike & 2'b01;
`endif

   // Search starts after the channel just captured so a lone channel is revisited.
   always_comb begin
      base_ch = (state == CAPT) ? ch : last_ch;
      next_ch = base_ch;
      for (int i = 4; i >= 1; i--) begin
         if (ch_en[base_ch + 2'(i)]) next_ch = base_ch + 2'(i);
      end
      load_prev = ((state == CAPT) && (next_ch == ch)) ? core_prev : prev[next_ch];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         ch              <= 2'd0;
         last_ch         <= 2'd3;
         core_data       <= 4'd0;
         core_force_prev <= 4'd0;
         core_load_prev  <= 1'b0;
         for (int i = 0; i < 4; i++) prev[i] <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start_next) begin
                  state           <= LOAD;
                  ch              <= next_ch;
                  core_data       <= sample[{next_ch, 2'b00} +: 4];
                  core_force_prev <= load_prev;
                  core_load_prev  <= 1'b1;
               end
            end
            LOAD: begin
               state          <= EVAL;
               core_load_prev <= 1'b0;
            end
            EVAL: state <= CAPT;
            CAPT: begin
               prev[ch] <= core_prev;
               last_ch  <= ch;
               if (start_next) begin
                  state           <= LOAD;
                  ch              <= next_ch;
                  core_data       <= sample[{next_ch, 2'b00} +: 4];
                  core_force_prev <= load_prev;
                  core_load_prev  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign push      = (state == CAPT) && (spike_m != 2'b00);
   assign pop       = (count != '0) && evt_ready;
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign push_ok   = push && (!full || pop);
   assign evt_valid = (count != '0);
   assign evt_data  = evt_valid ? mem[rd_ptr] : 4'd0;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {ch, spike_m};
   end

   // A drop and a clear in the same cycle leave the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW+1)'(1);
         else if (!push_ok && pop) count <= count - (AW+1)'(1);
         if (push && full && !pop) overflow <= 1'b1;
         else if (ovf_clr)         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_delta_mod_scheduler.sv
// Testbench for delta_mod_scheduler: behavioural core plus scheduler/FIFO reference model.
module tb_delta_mod_scheduler;

   localparam int DEPTH = 4;
`ifdef DMS_OFF_SPIKE_EN
   localparam bit OFF_EN = 1'b1;
`else
   localparam bit OFF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, ena, evt_ready, ovf_clr;
   logic [15:0] sample;
   logic [3:0]  threshold, ch_en;
   logic [3:0]  core_data, core_threshold, core_force_prev, evt_data;
   logic        core_load_prev, core_off_spike, evt_valid, overflow, busy;
   logic [1:0]  core_spike = 2'b00;
   logic [3:0]  core_prev  = 4'd0;

   logic [3:0]  bc_prev = 4'd0;
   logic        bc_eval = 1'b0;
   logic        force_en;
   logic [1:0]  force_spike;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   delta_mod_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sample(sample), .threshold(threshold),
      .ch_en(ch_en), .core_data(core_data), .core_threshold(core_threshold),
      .core_load_prev(core_load_prev), .core_force_prev(core_force_prev),
      .core_off_spike(core_off_spike), .core_spike(core_spike), .core_prev(core_prev),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
      .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy)
   );

   // Delta-mod rule: spike on a move beyond the threshold, then track the sample.
   function automatic logic [5:0] core_rule(input logic [3:0] d, input logic [3:0] p, input logic [3:0] t);
      int di = int'(d);
      int pi = int'(p);
      int ti = int'(t);
      if (di > pi + ti) return {2'b01, d};
      if (di + ti < pi) return {2'b10, d};
      return {2'b00, p};
   endfunction

   function automatic logic [3:0] nib(input logic [15:0] s, input int n);
      return s[n*4 +: 4];
   endfunction

   function automatic int rr_next(input int last, input logic [3:0] m);
      for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
      return last;
   endfunction

   // External core with one cycle of latency from EVAL.
   always @(posedge clk) begin
      bc_eval <= core_load_prev;
      if (core_load_prev) bc_prev <= core_force_prev;
      if (bc_eval) begin
         if (force_en) begin
            core_spike <= force_spike;
            core_prev  <= bc_prev;
         end else begin
            {core_spike, core_prev} <= core_rule(core_data, bc_prev, core_threshold);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ena = 1'b0; ch_en = 4'd0; evt_ready = 1'b0; ovf_clr = 1'b0;
      force_en = 1'b0; force_spike = 2'b00; sample = 16'd0; threshold = 4'd0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      threshold = 4'(($urandom % 15) + 1);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (evt_valid !== 1'b0 || evt_data !== 4'd0) begin errors++; $display("[TB] FAIL reset_evt: got %b/%h expected 0/0", evt_valid, evt_data); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
      checks++; if (core_load_prev !== 1'b0 || core_force_prev !== 4'd0 || core_data !== 4'd0) begin
         errors++; $display("[TB] FAIL reset_core: got %b/%h/%h expected 0/0/0", core_load_prev, core_force_prev, core_data); end
      checks++; if (core_off_spike !== OFF_EN) begin errors++; $display("[TB] FAIL off_spike: got %b expected %b", core_off_spike, OFF_EN); end
      checks++; if (core_threshold !== threshold) begin errors++; $display("[TB] FAIL core_thr: got %h expected %h", core_threshold, threshold); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_ena: got %b expected 0", busy); end
   endtask

   task automatic test_single_channel();
      do_reset();
      ch_en = 4'b0001; ena = 1'b1;
      tick();
      for (int c = 0; c < 9; c++) begin
         checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy c%0d: got %b expected 1", c, busy); end
         checks++; if (core_load_prev !== (c % 3 == 0)) begin
            errors++; $display("[TB] FAIL single_load c%0d: got %b expected %b", c, core_load_prev, (c % 3 == 0)); end
         if (c == 0) begin
            checks++; if (core_force_prev !== 4'd0) begin errors++; $display("[TB] FAIL single_force: got %h expected 0", core_force_prev); end
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_seq [6];
      exp_seq = '{4'hA, 4'hB, 4'hD, 4'hA, 4'hB, 4'hD};
      do_reset();
      sample = 16'hDCBA; threshold = 4'hF; ch_en = 4'b1011; ena = 1'b1;
      tick();
      for (int c = 0; c < 18; c++) begin
         checks++; if (core_load_prev !== (c % 3 == 0)) begin
            errors++; $display("[TB] FAIL rr_load c%0d: got %b expected %b", c, core_load_prev, (c % 3 == 0)); end
         if (c % 3 == 0) begin
            checks++; if (core_data !== exp_seq[c/3]) begin
               errors++; $display("[TB] FAIL rr_order c%0d: got %h expected %h", c, core_data, exp_seq[c/3]); end
         end
         tick();
      end
   endtask

   task automatic test_prev_update();
      do_reset();
      ch_en = 4'b0100; sample = 16'h0500; threshold = 4'd0; ena = 1'b1;
      tick();
      checks++; if (core_load_prev !== 1'b1 || core_force_prev !== 4'd0 || core_data !== 4'd5) begin
         errors++; $display("[TB] FAIL prev_first: got %b/%h/%h expected 1/0/5", core_load_prev, core_force_prev, core_data); end
      tick(); tick(); tick();
      checks++; if (core_load_prev !== 1'b1 || core_force_prev !== 4'd5) begin
         errors++; $display("[TB] FAIL prev_reload: got %b/%h expected 1/5", core_load_prev, core_force_prev); end
      checks++; if (evt_valid !== 1'b1 || evt_data !== 4'b1001) begin
         errors++; $display("[TB] FAIL prev_event: got %b/%b expected 1/1001", evt_valid, evt_data); end
   endtask

   task automatic test_no_abort();
      do_reset();
      ch_en = 4'b0010; sample = 16'h0070; threshold = 4'd0; ena = 1'b1;
      tick();
      tick();
      ena = 1'b0; ch_en = 4'b0000;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL noabort_eval: got %b expected 1", busy); end
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL noabort_capt: got %b expected 1", busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL noabort_idle: got %b expected 0", busy); end
      checks++; if (evt_valid !== 1'b1 || evt_data !== 4'b0101) begin
         errors++; $display("[TB] FAIL noabort_event: got %b/%b expected 1/0101", evt_valid, evt_data); end
   endtask

   task automatic test_overflow();
      int pops;
      do_reset();
      force_en = 1'b1; force_spike = 2'b01; ch_en = 4'b0001; ena = 1'b1;
      tick();
      for (int c = 0; c <= 20; c++) begin
         if (c == 12) begin
            checks++; if (overflow !== 1'b0 || evt_valid !== 1'b1) begin
               errors++; $display("[TB] FAIL ovf_four: got %b/%b expected 0/1", overflow, evt_valid); end
         end
         if (c == 15) begin
            checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
         end
         if (c == 18) begin
            checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins: got %b expected 1", overflow); end
         end
         if (c == 19) begin
            checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
         end
         ovf_clr = (c == 17) || (c == 18);
         if (c == 18) begin force_spike = 2'b00; ena = 1'b0; end
         tick();
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_idle: got %b expected 0", busy); end
      evt_ready = 1'b1; pops = 0;
      for (int k = 0; k < 10; k++) begin
         if (evt_valid) begin
            pops++;
            checks++; if (evt_data !== 4'b0001) begin errors++; $display("[TB] FAIL ovf_data: got %b expected 0001", evt_data); end
         end
         tick();
      end
      checks++; if (pops != DEPTH) begin errors++; $display("[TB] FAIL ovf_retained: got %0d expected %0d", pops, DEPTH); end
   endtask

   task automatic test_full_pop();
      int pops;
      do_reset();
      force_en = 1'b1; force_spike = 2'b01; ch_en = 4'b0001; ena = 1'b1;
      tick();
      for (int c = 0; c <= 17; c++) begin
         if (c == 15) begin
            checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_ovf: got %b expected 0", overflow); end
            force_spike = 2'b00; ena = 1'b0;
         end
         evt_ready = (c == 14);
         tick();
      end
      tick();
      evt_ready = 1'b1; pops = 0;
      for (int k = 0; k < 10; k++) begin
         if (evt_valid) pops++;
         tick();
      end
      checks++; if (pops != DEPTH) begin errors++; $display("[TB] FAIL fullpop_count: got %0d expected %0d", pops, DEPTH); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_ovf_end: got %b expected 0", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ch_en = 4'b0001; sample = 16'h0009; threshold = 4'd0; ena = 1'b1;
      tick(); tick(); tick(); tick();
      checks++; if (core_load_prev !== 1'b1 || core_force_prev !== 4'd9) begin
         errors++; $display("[TB] FAIL mid_pre: got %b/%h expected 1/9", core_load_prev, core_force_prev); end
      tick();
      rst_n = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || evt_valid !== 1'b0 || evt_data !== 4'd0 || overflow !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset: got %b/%b/%h/%b expected 0/0/0/0", busy, evt_valid, evt_data, overflow); end
      checks++; if (core_load_prev !== 1'b0 || core_force_prev !== 4'd0 || core_data !== 4'd0) begin
         errors++; $display("[TB] FAIL mid_core: got %b/%h/%h expected 0/0/0", core_load_prev, core_force_prev, core_data); end
      rst_n = 1'b1;
      tick();
      checks++; if (core_load_prev !== 1'b1 || core_force_prev !== 4'd0 || core_data !== 4'd9) begin
         errors++; $display("[TB] FAIL mid_restart: got %b/%h/%h expected 1/0/9", core_load_prev, core_force_prev, core_data); end
      force_en = 1'b1; force_spike = 2'b10;
      tick(); tick(); tick();
      checks++; if (evt_valid !== OFF_EN || evt_data !== (OFF_EN ? 4'b0010 : 4'b0000)) begin
         errors++; $display("[TB] FAIL off_spike_event: got %b/%b expected %b/%b", evt_valid, evt_data, OFF_EN, (OFF_EN ? 4'b0010 : 4'b0000)); end
   endtask

   task automatic test_random(input int ncyc);
      logic [3:0] mask;
      logic [3:0] q [$];
      logic [3:0] mprev [4];
      logic [5:0] r;
      logic [1:0] spk;
      logic [3:0] ev;
      int mlast, cur, phase;
      bit movf, popd;
      do_reset();
      mask = 4'($urandom_range(1, 15));
      ch_en = mask; threshold = 4'($urandom_range(0, 3)); sample = 16'($urandom); ena = 1'b1;
      for (int i = 0; i < 4; i++) mprev[i] = 4'd0;
      mlast = 3; movf = 1'b0; cur = 0; ev = 4'd0;
      tick();
      for (int c = 0; c < ncyc; c++) begin
         phase = c % 3;
         if (phase == 0) cur = rr_next(mlast, mask);
         checks++; if (busy !== 1'b1 || core_load_prev !== (phase == 0) || core_data !== nib(sample, cur)) begin
            errors++; $display("[TB] FAIL rand_seq c%0d: got %b/%b/%h expected 1/%b/%h", c, busy, core_load_prev, core_data, (phase == 0), nib(sample, cur)); end
         if (phase == 0) begin
            checks++; if (core_force_prev !== mprev[cur]) begin
               errors++; $display("[TB] FAIL rand_prev c%0d: got %h expected %h", c, core_force_prev, mprev[cur]); end
         end
         checks++; if (evt_valid !== (q.size() != 0) || evt_data !== ((q.size() != 0) ? q[0] : 4'd0) || overflow !== movf) begin
            errors++; $display("[TB] FAIL rand_fifo c%0d: got %b/%h/%b expected %b/%h/%b", c, evt_valid, evt_data, overflow,
               (q.size() != 0), ((q.size() != 0) ? q[0] : 4'd0), movf); end
         evt_ready = ($urandom_range(0, 3) == 0);
         if (phase == 2) begin
            r = core_rule(nib(sample, cur), mprev[cur], threshold);
            spk = OFF_EN ? r[5:4] : {1'b0, r[4]};
            ev = {2'(cur), spk};
            sample = 16'($urandom);
         end
         tick();
         popd = (q.size() != 0) && evt_ready;
         if (phase == 2) begin
            mprev[cur] = r[3:0];
            mlast = cur;
         end
         if (popd) void'(q.pop_front());
         if (phase == 2 && spk != 2'b00) begin
            if (q.size() == DEPTH) movf = 1'b1;
            else q.push_back(ev);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_channel();
      test_round_robin();
      test_prev_update();
      test_no_abort();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      test_random(90);
      test_random(90);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
